// File: rtl/ram_maestro.sv
// Synchronous burst master for the asynchronous RAM port: N consecutive writes or reads
// from a base address, with EN isolated from address/data changes by a full setup cycle.
module ram_maestro #(
    parameter int ANCHO_DIR  = 8,
    parameter int ANCHO_DATO = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inicio,
    input  logic                  modo,
    input  logic [ANCHO_DIR-1:0]  dir_base,
    input  logic [ANCHO_DIR-1:0]  longitud,
    input  logic [ANCHO_DATO-1:0] dato_w,
    input  logic                  dato_w_valid,
    output logic                  dato_w_ready,
    output logic [ANCHO_DATO-1:0] dato_r,
    output logic                  dato_r_valid,
    output logic                  ocupado,
    output logic                  hecho,
    output logic [ANCHO_DIR-1:0]  direccion,
    output logic [ANCHO_DATO-1:0] dato_e,
    output logic                  EN,
    input  logic [ANCHO_DATO-1:0] dato_s
);

    typedef enum logic [2:0] {
        REPOSO,
        W_ESPERA,
        W_SETUP,
        W_PULSO,
        R_DIR,
        R_CAP,
        FIN
    } estado_t;

    estado_t               r_estado, w_estado_sig;
    logic [ANCHO_DIR-1:0]  r_ptr, w_ptr;
    logic [ANCHO_DIR-1:0]  r_restante, w_restante;
    logic [ANCHO_DIR-1:0]  r_dir, w_dir;
    logic [ANCHO_DATO-1:0] r_dato_e, w_dato_e;
    logic                  r_en, w_en;
    logic [ANCHO_DATO-1:0] r_dato_r, w_dato_r;
    logic                  r_dato_r_valid, w_dato_r_valid;
    logic                  r_ocupado, w_ocupado;
    logic                  r_hecho, w_hecho;

    always_comb begin
        // NOTE: every signal gets its hold/idle value first so no branch can leave one unassigned (no latches).
        w_estado_sig   = r_estado;
        w_ptr          = r_ptr;
        w_restante     = r_restante;
        w_dir          = r_dir;
        w_dato_e       = r_dato_e;
        w_en           = 1'b0;
        w_dato_r       = r_dato_r;
        w_dato_r_valid = 1'b0;
        w_ocupado      = r_ocupado;
        w_hecho        = 1'b0;

        case (r_estado)
            REPOSO: begin
                if (inicio) begin
                    w_ptr      = dir_base;
                    w_restante = longitud;
                    w_ocupado  = 1'b1;
                    if (longitud == '0) begin
                        w_estado_sig = FIN;
                    end else if (modo) begin
                        w_estado_sig = W_ESPERA;
                    end else begin
                        w_estado_sig = R_DIR;
                        w_dir        = dir_base;
                    end
                end
            end
            W_ESPERA: begin
                if (dato_w_valid) begin
                    w_dir        = r_ptr;
                    w_dato_e     = dato_w;
                    w_estado_sig = W_SETUP;
                end
            end
            W_SETUP: begin
                // EN rises only after address and data have been stable for this whole cycle
                w_en         = 1'b1;
                w_estado_sig = W_PULSO;
            end
            W_PULSO: begin
                w_ptr        = r_ptr + ANCHO_DIR'(1);
                w_restante   = r_restante - ANCHO_DIR'(1);
                w_estado_sig = (r_restante == ANCHO_DIR'(1)) ? FIN : W_ESPERA;
            end
            R_DIR: begin
                w_estado_sig = R_CAP;
            end
            R_CAP: begin
                w_dato_r       = dato_s;
                w_dato_r_valid = 1'b1;
                w_ptr          = r_ptr + ANCHO_DIR'(1);
                w_restante     = r_restante - ANCHO_DIR'(1);
                if (r_restante == ANCHO_DIR'(1)) begin
                    w_estado_sig = FIN;
                end else begin
                    w_estado_sig = R_DIR;
                    w_dir        = r_ptr + ANCHO_DIR'(1);
                end
            end
            FIN: begin
                // hecho and the falling ocupado appear together on the cycle after FIN
                w_ocupado    = 1'b0;
                w_hecho      = 1'b1;
                w_estado_sig = REPOSO;
            end
            default: begin
                w_estado_sig = REPOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado       <= REPOSO;
            r_ptr          <= '0;
            r_restante     <= '0;
            r_dir          <= '0;
            r_dato_e       <= '0;
            r_en           <= 1'b0;
            r_dato_r       <= '0;
            r_dato_r_valid <= 1'b0;
            r_ocupado      <= 1'b0;
            r_hecho        <= 1'b0;
        end else begin
            r_estado       <= w_estado_sig;
            r_ptr          <= w_ptr;
            r_restante     <= w_restante;
            r_dir          <= w_dir;
            r_dato_e       <= w_dato_e;
            r_en           <= w_en;
            r_dato_r       <= w_dato_r;
            r_dato_r_valid <= w_dato_r_valid;
            r_ocupado      <= w_ocupado;
            r_hecho        <= w_hecho;
        end
    end

    assign dato_w_ready = (r_estado == W_ESPERA);
    assign dato_r       = r_dato_r;
    assign dato_r_valid = r_dato_r_valid;
    assign ocupado      = r_ocupado;
    assign hecho        = r_hecho;
    assign direccion    = r_dir;
    assign dato_e       = r_dato_e;
    assign EN           = r_en;

endmodule

// File: tb/tb_ram_maestro.sv
// Bench for ram_maestro: drives bursts against a behavioural asynchronous RAM and checks
// EN pulses, read data and hecho through a scoreboard monitor sampling on the falling edge.
module tb_ram_maestro;

    logic       clk = 1'b0;
    logic       rst;
    logic       inicio;
    logic       modo;
    logic [7:0] dir_base;
    logic [7:0] longitud;
    logic [7:0] dato_w;
    logic       dato_w_valid;
    logic       dato_w_ready;
    logic [7:0] dato_r;
    logic       dato_r_valid;
    logic       ocupado;
    logic       hecho;
    logic [7:0] direccion;
    logic [7:0] dato_e;
    logic       EN;
    logic [7:0] dato_s;

    ram_maestro #(.ANCHO_DIR(8), .ANCHO_DATO(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .inicio       (inicio),
        .modo         (modo),
        .dir_base     (dir_base),
        .longitud     (longitud),
        .dato_w       (dato_w),
        .dato_w_valid (dato_w_valid),
        .dato_w_ready (dato_w_ready),
        .dato_r       (dato_r),
        .dato_r_valid (dato_r_valid),
        .ocupado      (ocupado),
        .hecho        (hecho),
        .direccion    (direccion),
        .dato_e       (dato_e),
        .EN           (EN),
        .dato_s       (dato_s)
    );

    always #5 clk = ~clk;

    // Behavioural asynchronous RAM: combinational read, write committed while EN is high.
    logic [7:0] ram [256];
    assign dato_s = ram[direccion];
    always @(posedge clk) if (EN === 1'b1) ram[direccion] <= dato_e;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard state: expected EN pulses {addr,data}, expected read bytes, hecho counts.
    logic [15:0] exp_w [$];
    logic [7:0]  exp_r [$];
    int          hecho_exp  = 0;
    int          hecho_seen = 0;
    logic        mon_on = 1'b0;

    int   cyc = 0;
    always @(posedge clk) cyc++;

    logic       prev_en;
    logic [7:0] prev_dir;
    logic [7:0] prev_de;
    int         last_rv = -1;

    always @(negedge clk) begin
        logic [15:0] ew;
        logic [7:0]  er;
        if (mon_on) begin
            if (prev_en === 1'b1) check("en_one_cycle", 32'(EN), 32'(0));
            if (EN === 1'b1) begin
                check("en_addr_stable", 32'(direccion), 32'(prev_dir));
                check("en_data_stable", 32'(dato_e), 32'(prev_de));
                if (exp_w.size() == 0) begin
                    check("en_unexpected", 32'(EN), 32'(0));
                end else begin
                    ew = exp_w.pop_front();
                    check("en_write", 32'({direccion, dato_e}), 32'(ew));
                end
            end
            if (dato_r_valid === 1'b1) begin
                if (last_rv >= 0 && cyc - last_rv <= 3) check("rv_spacing", 32'(cyc - last_rv), 32'(2));
                last_rv = cyc;
                if (exp_r.size() == 0) begin
                    check("rv_unexpected", 32'(dato_r_valid), 32'(0));
                end else begin
                    er = exp_r.pop_front();
                    check("read_data", 32'(dato_r), 32'(er));
                end
            end
            if (hecho === 1'b1) begin
                if (hecho_seen >= hecho_exp) begin
                    check("hecho_unexpected", 32'(hecho), 32'(0));
                end else begin
                    hecho_seen++;
                    check("hecho_ocupado_low", 32'(ocupado), 32'(0));
                end
            end
        end
        prev_en  = EN;
        prev_dir = direccion;
        prev_de  = dato_e;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic m, input logic [7:0] base, input logic [7:0] len);
        inicio   = 1'b1;
        modo     = m;
        dir_base = base;
        longitud = len;
        tick();
        inicio = 1'b0;
        check("ocupado_set", 32'(ocupado), 32'(1));
    endtask

    // Offers one byte; with stall>0 valid stays low for that many W_ESPERA cycles first.
    task automatic send_byte(input logic [7:0] d, input int stall);
        int t;
        dato_w       = d;
        dato_w_valid = (stall == 0);
        t = 0;
        while (dato_w_ready !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        check("ready_timeout", 32'(dato_w_ready), 32'(1));
        for (int k = 0; k < stall; k++) begin
            check("ready_during_stall", 32'(dato_w_ready), 32'(1));
            tick();
        end
        dato_w_valid = 1'b1;
        tick();
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (ocupado !== 1'b0 && t < 200) begin
            tick();
            t++;
        end
        check("burst_timeout", 32'(ocupado), 32'(0));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        inicio       = 1'b0;
        modo         = 1'b0;
        dir_base     = '0;
        longitud     = '0;
        dato_w       = '0;
        dato_w_valid = 1'b0;

        // Reset with random inputs: every output low.
        for (int i = 0; i < 2; i++) begin
            inicio       = 1'($urandom);
            modo         = 1'($urandom);
            dir_base     = 8'($urandom);
            longitud     = 8'($urandom);
            dato_w       = 8'($urandom);
            dato_w_valid = 1'($urandom);
            tick();
            check("reset_outputs",
                  32'({dato_w_ready, dato_r, dato_r_valid, ocupado, hecho, direccion, dato_e, EN}),
                  32'(0));
        end
        rst          = 1'b0;
        inicio       = 1'b0;
        dato_w_valid = 1'b0;
        mon_on       = 1'b1;
        tick();

        // Write burst 9..11 with valid held high.
        exp_w.push_back({8'd9, 8'd64});
        exp_w.push_back({8'd10, 8'd25});
        exp_w.push_back({8'd11, 8'd55});
        hecho_exp++;
        start(1'b1, 8'd9, 8'd3);
        send_byte(8'd64, 0);
        send_byte(8'd25, 0);
        send_byte(8'd55, 0);
        dato_w_valid = 1'b0;
        wait_idle();
        check("ram_9", 32'(ram[9]), 32'(64));
        check("ram_10", 32'(ram[10]), 32'(25));
        check("ram_11", 32'(ram[11]), 32'(55));

        // Read back the same three bytes.
        exp_r.push_back(8'd64);
        exp_r.push_back(8'd25);
        exp_r.push_back(8'd55);
        hecho_exp++;
        start(1'b0, 8'd9, 8'd3);
        wait_idle();

        // Wrapping write with a 5-cycle stall before the second byte.
        exp_w.push_back({8'd254, 8'd1});
        exp_w.push_back({8'd255, 8'd2});
        exp_w.push_back({8'd0, 8'd3});
        hecho_exp++;
        start(1'b1, 8'd254, 8'd3);
        send_byte(8'd1, 0);
        send_byte(8'd2, 5);
        send_byte(8'd3, 0);
        dato_w_valid = 1'b0;
        wait_idle();
        check("ram_254", 32'(ram[254]), 32'(1));
        check("ram_255", 32'(ram[255]), 32'(2));
        check("ram_0", 32'(ram[0]), 32'(3));

        // Zero length: hecho two cycles after inicio, no access.
        hecho_exp++;
        start(1'b1, 8'd40, 8'd0);
        check("zl_hecho_early", 32'(hecho), 32'(0));
        tick();
        check("zl_hecho", 32'(hecho), 32'(1));
        check("zl_ocupado", 32'(ocupado), 32'(0));
        tick();
        check("zl_hecho_one_cycle", 32'(hecho), 32'(0));

        // Reset during the second write pulse of a 4-byte burst.
        exp_w.push_back({8'd100, 8'hAA});
        exp_w.push_back({8'd101, 8'hBB});
        start(1'b1, 8'd100, 8'd4);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        dato_w_valid = 1'b0;
        tick();
        check("mid_en_pulse", 32'(EN), 32'(1));
        rst = 1'b1;
        tick();
        check("mid_rst_en", 32'(EN), 32'(0));
        check("mid_rst_ocupado", 32'(ocupado), 32'(0));
        check("mid_rst_ready", 32'(dato_w_ready), 32'(0));
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_rst_ram_base", 32'(ram[100]), 32'(8'hAA));

        // Normal burst after reset.
        exp_w.push_back({8'd12, 8'h77});
        exp_w.push_back({8'd13, 8'h88});
        hecho_exp++;
        start(1'b1, 8'd12, 8'd2);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        dato_w_valid = 1'b0;
        wait_idle();
        check("ram_12", 32'(ram[12]), 32'(8'h77));
        check("ram_13", 32'(ram[13]), 32'(8'h88));

        // Read of 4 with a second inicio issued while busy.
        exp_r.push_back(8'd64);
        exp_r.push_back(8'd25);
        exp_r.push_back(8'd55);
        exp_r.push_back(8'h77);
        hecho_exp++;
        start(1'b0, 8'd9, 8'd4);
        tick();
        inicio   = 1'b1;
        modo     = 1'b1;
        dir_base = 8'd50;
        longitud = 8'd1;
        tick();
        inicio = 1'b0;
        wait_idle();
        for (int i = 0; i < 4; i++) tick();
        check("idle_after_busy", 32'(ocupado), 32'(0));
        check("reads_outstanding", 32'(exp_r.size()), 32'(0));
        check("writes_outstanding", 32'(exp_w.size()), 32'(0));
        check("hecho_count", 32'(hecho_seen), 32'(hecho_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
